// File: rtl/ws2811_receiver.sv
// WS2811 single-wire receiver.
// Synchronises the line and measures each high pulse in clocks. The pulse is
// decoded as 0/1 by width, and the first 24-bit word of a frame is captured
// MSB first. Later bits are forwarded on forwardOUT. A long low gap ends the
// frame.
module ws2811_receiver #(
  parameter int CLOCK_SPEED         = 50_000_000,
  parameter int BIT_THRESHOLD_100NS = 8,
  parameter int MIN_HIGH_100NS      = 2,
  parameter int MAX_HIGH_100NS      = 20,
  parameter int RESET_GAP_100NS     = 500
) (
  input  logic        clkIN,
  input  logic        nResetIN,
  input  logic        dataIN,
  output logic [23:0] dataOUT,
  output logic        validOUT,
  output logic        latchOUT,
  output logic        errorOUT,
  output logic        forwardOUT,
  output logic        busyOUT
);

  localparam int T        = CLOCK_SPEED / 10_000_000;
  localparam int GAP_CLKS = RESET_GAP_100NS * T;
  localparam int CW       = $clog2(GAP_CLKS + 1);

  localparam logic [CW-1:0] GAP_C    = CW'(GAP_CLKS);
  localparam logic [CW-1:0] THRESH_C = CW'(BIT_THRESHOLD_100NS * T);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_HIGH_100NS * T);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_HIGH_100NS * T);

  typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

  state_t        state_reg, state_next;
  logic          s1, s2, s3;
  logic          level_change;
  logic [CW-1:0] cnt_reg;
  logic [4:0]    bit_cnt_reg, bit_cnt_next;
  logic [22:0]   shift_reg, shift_next;
  logic [23:0]   data_reg, data_next;
  logic          fwd_reg, fwd_next;
  logic          valid_reg, valid_next;
  logic          latch_reg, latch_next;
  logic          error_reg, error_next;
  logic          bit_val;

  assign level_change = s2 ^ s3;

  // Two-flop synchroniser plus one extra stage for edge detection.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= dataIN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Level-duration counter. It restarts at 1 on an edge, so it holds the
  // number of clocks already spent at the current level. It saturates at the
  // gap length. While waiting for a gap, a high line holds it at zero.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      cnt_reg <= '0;
    end else if (level_change) begin
      cnt_reg <= CW'(1);
    end else if (state_reg == WAIT_GAP && s2) begin
      cnt_reg <= '0;
    end else if (cnt_reg != GAP_C) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // State, capture registers and registered pulse outputs.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state_reg   <= WAIT_GAP;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      fwd_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      latch_reg   <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      fwd_reg     <= fwd_next;
      valid_reg   <= valid_next;
      latch_reg   <= latch_next;
      error_reg   <= error_next;
    end
  end

  // Next-state logic: pulse classification, word assembly and frame end.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    fwd_next     = fwd_reg;
    valid_next   = 1'b0;
    latch_next   = 1'b0;
    error_next   = 1'b0;
    // On the falling-edge clock, cnt_reg equals the high width in clocks.
    bit_val      = (cnt_reg >= THRESH_C);

    case (state_reg)
      WAIT_GAP: begin
        if (!s2 && !level_change && cnt_reg == GAP_C) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        if (s2) begin
          bit_cnt_next = '0;
          fwd_next     = 1'b0;
          state_next   = HIGH;
        end
      end

      HIGH: begin
        if (s2) begin
          // A run of MAX+1 high clocks is already too long.
          if (cnt_reg >= MAX_C) begin
            error_next   = 1'b1;
            fwd_next     = 1'b0;
            bit_cnt_next = '0;
            state_next   = WAIT_GAP;
          end
        end else if (cnt_reg < MIN_C) begin
          error_next   = 1'b1;
          fwd_next     = 1'b0;
          bit_cnt_next = '0;
          state_next   = WAIT_GAP;
        end else begin
          state_next = LOW;
          if (!fwd_reg) begin
            shift_next = {shift_reg[21:0], bit_val};
            if (bit_cnt_reg == 5'd23) begin
              data_next    = {shift_reg, bit_val};
              valid_next   = 1'b1;
              fwd_next     = 1'b1;
              bit_cnt_next = '0;
            end else begin
              bit_cnt_next = bit_cnt_reg + 5'd1;
            end
          end
        end
      end

      LOW: begin
        if (s2) begin
          state_next = HIGH;
        end else if (cnt_reg == GAP_C) begin
          // A gap ends the frame. A complete word latches.
          // A partial word is a framing error.
          state_next = IDLE;
          fwd_next   = 1'b0;
          if (bit_cnt_reg == 5'd0 && fwd_reg) begin
            latch_next = 1'b1;
          end else begin
            error_next = 1'b1;
          end
          bit_cnt_next = '0;
        end
      end

      default: state_next = WAIT_GAP;
    endcase
  end

  assign dataOUT    = data_reg;
  assign validOUT   = valid_reg;
  assign latchOUT   = latch_reg;
  assign errorOUT   = error_reg;
  assign forwardOUT = s2 & fwd_reg;
  assign busyOUT    = (state_reg == HIGH) || (state_reg == LOW);

endmodule
